lnrv_axi2icb: RTL and testbench

AXI4 slave to ICB master bridge, converting external AXI initiator traffic into single-beat ICB commands for on-chip ICB peripherals and memories. It accepts one AXI transaction at a time (read or write, round-robin arbitrated) and splits bursts of up to 256 beats into sequential ICB command/response pairs. AXI write responses and read data are returned in order. It is the slave-side counterpart of the ICB-to-AXI master bridge on the system bus.

---
 rtl/lnrv_axi2icb.sv | 192 +++++++++++++++++++
 tb/tb_lnrv_axi2icb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lnrv_axi2icb.sv
// lnrv_axi2icb: AXI4 slave to ICB master bridge.
//
// Handles one AXI transaction at a time. Reads and writes are arbitrated
// round-robin. Each burst of up to 256 beats is issued as a sequence of
// single-beat ICB command/response pairs. At most one ICB command is in
// flight at any time.
//
// Ports:
//   clk, reset_n                     clock; asynchronous active-low reset
//   axi_aw*/axi_ar*                  address channels (addr, id, len, size, burst)
//   axi_w*                           write data channel (wlast ignored, beat counter governs)
//   axi_b*                           write response, one per burst, sticky error
//   axi_r*                           read data, one beat per ICB response
//   icb_cmd_*                        ICB command (vld/rdy, write, addr, size, wdata, wstrb)
//   icb_rsp_*                        ICB response (vld/rdy, err, rdata)
module lnrv_axi2icb #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [P_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [P_ID_WIDTH-1:0]     axi_awid,
  input  logic [7:0]                axi_awlen,
  input  logic [2:0]                axi_awsize,
  input  logic [1:0]                axi_awburst,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  input  logic [P_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [P_ID_WIDTH-1:0]     axi_arid,
  input  logic [7:0]                axi_arlen,
  input  logic [2:0]                axi_arsize,
  input  logic [1:0]                axi_arburst,
  input  logic                      axi_wvalid,
  input  logic                      axi_wlast,
  output logic                      axi_wready,
  input  logic [P_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  output logic [P_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                axi_bresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [P_ID_WIDTH-1:0]     axi_rid,
  output logic [1:0]                axi_rresp,
  output logic [P_DATA_WIDTH-1:0]   axi_rdata,
  output logic                      axi_rlast,
  output logic                      icb_cmd_vld,
  input  logic                      icb_cmd_rdy,
  output logic                      icb_cmd_write,
  output logic [P_ADDR_WIDTH-1:0]   icb_cmd_addr,
  output logic [2:0]                icb_cmd_size,
  output logic [P_DATA_WIDTH-1:0]   icb_cmd_wdata,
  output logic [P_DATA_WIDTH/8-1:0] icb_cmd_wstrb,
  input  logic                      icb_rsp_vld,
  output logic                      icb_rsp_rdy,
  input  logic                      icb_rsp_err,
  input  logic [P_DATA_WIDTH-1:0]   icb_rsp_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WCMD, ST_WRSP, ST_BRESP, ST_RCMD, ST_RRSP
  } state_e;

  localparam logic [P_ADDR_WIDTH-1:0] LP_ONE = P_ADDR_WIDTH'(1);

  state_e                    state_q;
  logic                      prio_w_q;   // 1: write wins a simultaneous request
  logic                      run_q;      // low for the first cycle after reset so readies stay 0 in reset
  logic [P_ADDR_WIDTH-1:0]   addr_q;
  logic [P_ID_WIDTH-1:0]     id_q;
  logic [7:0]                cnt_q;      // beats remaining after the current one
  logic [7:0]                len_q;      // original len, needed for the WRAP boundary
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;      // sticky error over a write burst

  logic                      grant_w, grant_r;
  logic [P_ADDR_WIDTH-1:0]   step, wrap_mask, addr_inc, addr_adv;
  logic                      unused_wlast;

  assign unused_wlast = axi_wlast;

  assign grant_w = run_q & (state_q == ST_IDLE) & axi_awvalid & (~axi_arvalid | prio_w_q);
  assign grant_r = run_q & (state_q == ST_IDLE) & axi_arvalid & ~grant_w;

  // Next beat address. WRAP keeps the bits above the aligned wrap window
  // and lets only the low bits roll over.
  always_comb begin
    step      = LP_ONE << size_q;
    wrap_mask = ((P_ADDR_WIDTH'(len_q) + LP_ONE) << size_q) - LP_ONE;
    addr_inc  = addr_q + step;
    addr_adv  = addr_inc;
    case (burst_q)
      2'b00:   addr_adv = addr_q;
      2'b10:   addr_adv = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_adv = addr_inc;
    endcase
  end

  // AXI side
  assign axi_awready = grant_w;
  assign axi_arready = grant_r;
  assign axi_wready  = (state_q == ST_WCMD) & icb_cmd_rdy;
  assign axi_bvalid  = (state_q == ST_BRESP);
  assign axi_bresp   = {(state_q == ST_BRESP) & err_q, 1'b0};
  assign axi_bid     = id_q;
  assign axi_rvalid  = (state_q == ST_RRSP) & icb_rsp_vld;
  assign axi_rdata   = (state_q == ST_RRSP) ? icb_rsp_rdata : '0;
  assign axi_rresp   = {(state_q == ST_RRSP) & icb_rsp_err, 1'b0};
  assign axi_rlast   = (state_q == ST_RRSP) & (cnt_q == 8'd0);
  assign axi_rid     = id_q;

  // ICB side; write payload passes through only while a write command is presented
  assign icb_cmd_vld   = ((state_q == ST_WCMD) & axi_wvalid) | (state_q == ST_RCMD);
  assign icb_cmd_write = (state_q == ST_WCMD);
  assign icb_cmd_addr  = addr_q;
  assign icb_cmd_size  = size_q;
  assign icb_cmd_wdata = (state_q == ST_WCMD) ? axi_wdata : '0;
  assign icb_cmd_wstrb = (state_q == ST_WCMD) ? axi_wstrb : '0;
  assign icb_rsp_rdy   = (state_q == ST_WRSP) | ((state_q == ST_RRSP) & axi_rready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      prio_w_q <= 1'b1;
      run_q    <= 1'b0;
      addr_q   <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (grant_w || grant_r) begin
            addr_q   <= grant_w ? axi_awaddr  : axi_araddr;
            id_q     <= grant_w ? axi_awid    : axi_arid;
            cnt_q    <= grant_w ? axi_awlen   : axi_arlen;
            len_q    <= grant_w ? axi_awlen   : axi_arlen;
            size_q   <= grant_w ? axi_awsize  : axi_arsize;
            burst_q  <= grant_w ? axi_awburst : axi_arburst;
            err_q    <= 1'b0;
            prio_w_q <= grant_r;
            state_q  <= grant_w ? ST_WCMD : ST_RCMD;
          end
        end
        ST_WCMD: begin
          if (axi_wvalid && icb_cmd_rdy) state_q <= ST_WRSP;
        end
        ST_WRSP: begin
          if (icb_rsp_vld) begin
            err_q <= err_q | icb_rsp_err;
            if (cnt_q == 8'd0) begin
              state_q <= ST_BRESP;
            end else begin
              cnt_q   <= cnt_q - 8'd1;
              addr_q  <= addr_adv;
              state_q <= ST_WCMD;
            end
          end
        end
        ST_BRESP: begin
          if (axi_bready) state_q <= ST_IDLE;
        end
        ST_RCMD: begin
          if (icb_cmd_rdy) state_q <= ST_RRSP;
        end
        ST_RRSP: begin
          if (icb_rsp_vld && axi_rready) begin
            if (cnt_q == 8'd0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= cnt_q - 8'd1;
              addr_q  <= addr_adv;
              state_q <= ST_RCMD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lnrv_axi2icb.sv
module tb_lnrv_axi2icb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        axi_awvalid = 0, axi_arvalid = 0, axi_wvalid = 0, axi_wlast = 0;
  logic        axi_bready = 0, axi_rready = 0;
  logic [31:0] axi_awaddr = 0, axi_araddr = 0, axi_wdata = 0;
  logic [3:0]  axi_awid = 0, axi_arid = 0, axi_wstrb = 0;
  logic [7:0]  axi_awlen = 0, axi_arlen = 0;
  logic [2:0]  axi_awsize = 0, axi_arsize = 0;
  logic [1:0]  axi_awburst = 0, axi_arburst = 0;
  logic        axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast;
  logic [3:0]  axi_bid, axi_rid;
  logic [1:0]  axi_bresp, axi_rresp;
  logic [31:0] axi_rdata;
  logic        icb_cmd_vld, icb_cmd_write, icb_rsp_rdy;
  logic        icb_cmd_rdy = 1'b1;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [2:0]  icb_cmd_size;
  logic [3:0]  icb_cmd_wstrb;
  logic        icb_rsp_vld, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;

  always #5 clk = ~clk;

  lnrv_axi2icb dut (
    .clk(clk), .reset_n(reset_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_rresp(axi_rresp),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy), .icb_cmd_write(icb_cmd_write),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_size(icb_cmd_size),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wstrb(icb_cmd_wstrb),
    .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy), .icb_rsp_err(icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata)
  );

  // Zero-wait ICB slave: answers every command on the following cycle and
  // logs every command it accepts.
  logic [31:0] err_addr = 32'hFFFF_FFF0;
  logic        rsp_pend, rsp_err_r;
  logic [31:0] rsp_data;
  int          log_n = 0;
  logic [31:0] log_addr  [256];
  logic [31:0] log_wdata [256];
  logic [3:0]  log_wstrb [256];
  logic        log_write [256];
  logic [2:0]  log_size  [256];

  assign icb_rsp_vld   = rsp_pend;
  assign icb_rsp_err   = rsp_err_r;
  assign icb_rsp_rdata = rsp_data;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_pend  <= 1'b0;
      rsp_err_r <= 1'b0;
      rsp_data  <= '0;
    end else if (icb_cmd_vld && icb_cmd_rdy) begin
      rsp_pend  <= 1'b1;
      rsp_data  <= icb_cmd_addr ^ 32'h5A5A_0000;
      rsp_err_r <= (icb_cmd_addr == err_addr);
      log_addr[log_n % 256]  <= icb_cmd_addr;
      log_wdata[log_n % 256] <= icb_cmd_wdata;
      log_wstrb[log_n % 256] <= icb_cmd_wstrb;
      log_write[log_n % 256] <= icb_cmd_write;
      log_size[log_n % 256]  <= icb_cmd_size;
      log_n <= log_n + 1;
    end else if (rsp_pend && icb_rsp_rdy) begin
      rsp_pend <= 1'b0;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Wait (sampling at negedge) until the selected output is high; returns cycles waited.
  task automatic wait_hi(input int which, input string name, output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cyc = c + 1;
      case (which)
        0: seen = axi_awready;
        1: seen = axi_arready;
        2: seen = axi_wready;
        3: seen = axi_bvalid;
        default: seen = axi_rvalid;
      endcase
      if (seen) break;
    end
    if (!seen) timeout(name);
  endtask

  typedef struct packed {
    bit              wr;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [3:0]      id;
    logic [31:0]     err_addr;
    logic [1:0]      exp_bresp;
    logic [3:0][31:0] exp_a;
  } txn_t;

  function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                              input logic [31:0] ea, input logic [1:0] br,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    txn_t t;
    t.wr = wr; t.addr = addr; t.len = len; t.size = size; t.burst = burst; t.id = id;
    t.err_addr = ea; t.exp_bresp = br;
    t.exp_a[0] = a0; t.exp_a[1] = a1; t.exp_a[2] = a2; t.exp_a[3] = a3;
    return t;
  endfunction

  task automatic run_txn(input txn_t t, input int idx);
    int base, cyc;
    base = log_n;
    err_addr = t.err_addr;
    if (t.wr) begin
      axi_awvalid = 1; axi_awaddr = t.addr; axi_awlen = t.len; axi_awsize = t.size;
      axi_awburst = t.burst; axi_awid = t.id;
      wait_hi(0, "awready", cyc);
      @(posedge clk); #1 axi_awvalid = 0;
      for (int b = 0; b <= int'(t.len); b++) begin
        axi_wvalid = 1; axi_wdata = 32'hDEAD_BEEF ^ (32'(b) << 8); axi_wstrb = 4'hF ^ 4'(b);
        axi_wlast = (b == int'(t.len));
        wait_hi(2, "wready", cyc);
        @(posedge clk); #1;
      end
      axi_wvalid = 0; axi_wlast = 0;
      axi_bready = 1;
      wait_hi(3, "bvalid", cyc);
      check("b_latency", 64'(cyc), 64'd2);
      check("bresp", 64'(axi_bresp), 64'(t.exp_bresp));
      check("bid", 64'(axi_bid), 64'(t.id));
      @(posedge clk); #1 axi_bready = 0;
    end else begin
      axi_arvalid = 1; axi_araddr = t.addr; axi_arlen = t.len; axi_arsize = t.size;
      axi_arburst = t.burst; axi_arid = t.id;
      wait_hi(1, "arready", cyc);
      @(posedge clk); #1 axi_arvalid = 0;
      axi_rready = 1;
      for (int b = 0; b <= int'(t.len); b++) begin
        wait_hi(4, "rvalid", cyc);
        if (b == 0) check("r_latency", 64'(cyc), 64'd2);
        check("rdata", 64'(axi_rdata), 64'(t.exp_a[b] ^ 32'h5A5A_0000));
        check("rlast", 64'(axi_rlast), 64'(b == int'(t.len)));
        check("rresp", 64'(axi_rresp), (t.exp_a[b] == t.err_addr) ? 64'd2 : 64'd0);
        check("rid", 64'(axi_rid), 64'(t.id));
        @(posedge clk); #1;
      end
      axi_rready = 0;
    end
    #1;
    check("icb_cmd_count", 64'(log_n - base), 64'(int'(t.len) + 1));
    for (int k = 0; k <= int'(t.len); k++) begin
      check("icb_addr", 64'(log_addr[(base + k) % 256]), 64'(t.exp_a[k]));
      check("icb_write", 64'(log_write[(base + k) % 256]), 64'(t.wr));
      check("icb_size", 64'(log_size[(base + k) % 256]), 64'(t.size));
      if (t.wr) begin
        check("icb_wdata", 64'(log_wdata[(base + k) % 256]), 64'(32'hDEAD_BEEF ^ (32'(k) << 8)));
        check("icb_wstrb", 64'(log_wstrb[(base + k) % 256]), 64'(4'hF ^ 4'(k)));
      end
    end
    $display("txn %0d: %s addr=0x%08h len=%0d burst=%0d id=%0d done", idx, t.wr ? "WR" : "RD",
             t.addr, t.len, t.burst, t.id);
  endtask

  function automatic logic [63:0] out_or();
    return 64'(axi_awready | axi_arready | axi_wready | axi_bvalid | axi_rvalid | axi_rlast |
               (|axi_bresp) | (|axi_rresp) | (|axi_bid) | (|axi_rid) | (|axi_rdata) |
               icb_cmd_vld | icb_cmd_write | (|icb_cmd_addr) | (|icb_cmd_size) |
               (|icb_cmd_wdata) | (|icb_cmd_wstrb) | icb_rsp_rdy);
  endfunction

  txn_t tbl [8];
  localparam logic [31:0] NOERR = 32'hFFFF_FFF0;

  initial begin
    tbl[0] = mk(1, 32'h100, 0, 2, 2'b01, 4'd3, NOERR, 2'b00, 32'h100, 0, 0, 0);
    tbl[1] = mk(0, 32'h200, 3, 2, 2'b01, 4'd5, NOERR, 2'b00, 32'h200, 32'h204, 32'h208, 32'h20C);
    tbl[2] = mk(0, 32'h038, 3, 2, 2'b10, 4'd6, 32'h30, 2'b00, 32'h038, 32'h03C, 32'h030, 32'h034);
    tbl[3] = mk(1, 32'h400, 3, 2, 2'b01, 4'd9, 32'h404, 2'b10, 32'h400, 32'h404, 32'h408, 32'h40C);
    tbl[4] = mk(0, 32'h080, 1, 2, 2'b00, 4'd1, NOERR, 2'b00, 32'h080, 32'h080, 0, 0);
    tbl[5] = mk(1, 32'h01C, 1, 2, 2'b10, 4'd2, NOERR, 2'b00, 32'h01C, 32'h018, 0, 0);
    tbl[6] = mk(0, 32'hFFFF_FFFC, 1, 2, 2'b11, 4'd15, NOERR, 2'b00, 32'hFFFF_FFFC, 32'h0, 0, 0);
    tbl[7] = mk(1, 32'h600, 2, 1, 2'b01, 4'd4, 32'h602, 2'b10, 32'h600, 32'h602, 32'h604, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", out_or(), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], i);

    // Round-robin with both requests held high from reset
    begin
      int   n, cyc_guard;
      logic [3:0] seq;
      n = 0; seq = '0;
      @(negedge clk) reset_n = 1'b0;
      axi_awvalid = 1; axi_awaddr = 32'h10; axi_awlen = 0; axi_awsize = 2; axi_awburst = 1; axi_awid = 1;
      axi_arvalid = 1; axi_araddr = 32'h20; axi_arlen = 0; axi_arsize = 2; axi_arburst = 1; axi_arid = 2;
      axi_wvalid = 1; axi_wdata = 32'h1234_5678; axi_wstrb = 4'hF; axi_wlast = 1;
      axi_bready = 1; axi_rready = 1;
      @(negedge clk);
      check("rst_awready_held_low", 64'(axi_awready | axi_arready), 64'd0);
      reset_n = 1'b1;
      cyc_guard = 0;
      while (n < 4 && cyc_guard < 100) begin
        @(negedge clk);
        cyc_guard++;
        if (axi_awready && axi_arready) check("both_ready", 64'd1, 64'd0);
        if (axi_awready) begin seq[n] = 1'b1; n++; end
        else if (axi_arready) begin seq[n] = 1'b0; n++; end
      end
      if (n < 4) timeout("grant_sequence");
      else check("grant_order_WRWR", 64'(seq), 64'b0101);
      $display("arbitration: grants seq=%b (bit0 first, 1=W)", seq);
      @(posedge clk); #1;
      axi_awvalid = 0; axi_arvalid = 0; axi_wvalid = 0; axi_wlast = 0;
      repeat (6) @(posedge clk);
      #1 axi_bready = 0; axi_rready = 0;
    end

    // Reset during beat 2 of an 8-beat read
    begin
      int cyc;
      err_addr = NOERR;
      axi_arvalid = 1; axi_araddr = 32'h300; axi_arlen = 7; axi_arsize = 2; axi_arburst = 1; axi_arid = 8;
      wait_hi(1, "arready_8beat", cyc);
      @(posedge clk); #1 axi_arvalid = 0;
      axi_rready = 1;
      wait_hi(4, "rvalid_beat1", cyc);
      check("beat1_rdata", 64'(axi_rdata), 64'(32'h300 ^ 32'h5A5A_0000));
      @(posedge clk);          // beat 1 accepted, RCMD for beat 2
      @(posedge clk); #2;      // beat 2 response presented
      check("beat2_rvalid", 64'(axi_rvalid), 64'd1);
      reset_n = 1'b0;
      #1;
      check("midburst_reset_outputs", out_or(), 64'd0);
      axi_rready = 0;
      $display("reset asserted during beat 2 of 8-beat read");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_txn(mk(0, 32'h500, 0, 2, 2'b01, 4'd7, NOERR, 2'b00, 32'h500, 0, 0, 0), 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
